hilo_ctrl: RTL and testbench

Sequencing controller for the HI/LO unit in the EX stage. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the execute stage and owns the architectural HI and LO registers. Multiplies and moves complete in one cycle; divides run on an instance of the iterative `div` datapath, which this block enables, holds and retires. It exports `busy` so the hazard unit can stall MFHI/MFLO and later HI/LO operations.

---
 rtl/hilo_pkg.sv | 25 ++
 rtl/hilo_ctrl_div.sv | 92 +++++++++
 rtl/hilo_ctrl.sv | 147 ++++++++++++++
 tb/tb_hilo_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO sequencing controller.
//   - operation encodings carried on hilo_ctrl.op
//   - FSM state encodings for hilo_ctrl
//   - divide latency helper: cycles the divider is enabled, WIDTH + 2
//     (one operand-load cycle, WIDTH iterations, one completion cycle)
package hilo_pkg;

    localparam int HILO_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    // 3'd6 and 3'd7 are reserved and behave as no-ops.

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_DIV_RUN = 1'b1;

    function automatic int div_latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/hilo_ctrl_div.sv
// div: iterative restoring divider used by hilo_ctrl.
// Runs while en is high; operands must be held stable for the whole run.
// Cycle 0 of a run captures operand magnitudes and result signs, cycles
// 1..WIDTH each retire one quotient bit, and cycle WIDTH+1 raises complete
// with the sign-corrected results on quotient/remainder.
// Signed results truncate toward zero; the remainder follows the dividend.
// A zero divisor simply runs to completion with undefined-but-harmless data.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset (also used to abort a run)
//   en         run enable; dropping it restarts the sequence
//   signed_op  1 = signed divide, 0 = unsigned
//   dividend   WIDTH-bit dividend
//   divisor    WIDTH-bit divisor
//   complete   results valid this cycle
//   quotient   WIDTH-bit quotient
//   remainder  WIDTH-bit remainder
module div
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             complete,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int LAT   = div_latency(WIDTH);
    localparam int CNT_W = $clog2(LAT);

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic neg);
        return neg ? (~v + WIDTH'(1)) : v;
    endfunction

    logic [CNT_W-1:0] cnt_p0;
    logic [WIDTH-1:0] rem_p1;
    logic [WIDTH-1:0] quo_p1;
    logic [WIDTH-1:0] dvs_p1;
    logic             neg_q_p1;
    logic             neg_r_p1;
    logic [WIDTH:0]   rem_w;
    logic [WIDTH:0]   diff;

    assign complete = en && (cnt_p0 == CNT_W'(LAT - 1));

    // Stage 0: cycle counter, the only control state in the divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_p0 <= '0;
        end else if (!en) begin
            cnt_p0 <= '0;
        end else if (!complete) begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
        end
    end

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    assign rem_w = {rem_p1, quo_p1[WIDTH-1]};
    assign diff  = rem_w - {1'b0, dvs_p1};

    // Stage 1: operand magnitudes and one restoring step per cycle
    always_ff @(posedge clk) begin
        if (en) begin
            if (cnt_p0 == '0) begin
                quo_p1   <= cond_neg(dividend, signed_op & dividend[WIDTH-1]);
                dvs_p1   <= cond_neg(divisor, signed_op & divisor[WIDTH-1]);
                rem_p1   <= '0;
                neg_q_p1 <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r_p1 <= signed_op & dividend[WIDTH-1];
            end else if (!complete) begin
                if (!diff[WIDTH]) begin
                    rem_p1 <= diff[WIDTH-1:0];
                    quo_p1 <= {quo_p1[WIDTH-2:0], 1'b1};
                end else begin
                    rem_p1 <= rem_w[WIDTH-1:0];
                    quo_p1 <= {quo_p1[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign quotient  = cond_neg(quo_p1, neg_q_p1);
    assign remainder = cond_neg(rem_p1, neg_r_p1);

endmodule

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO sequencing controller for the EX stage.
// Owns the architectural HI/LO registers. MULT/MULTU/MTHI/MTLO complete in
// one cycle; DIV/DIVU latch their operands and run the iterative divider
// u_div for WIDTH+2 cycles while busy is high.
// Build option: define HILO_DIV_ZERO_FAST_EN to retire a zero-divisor
// DIV/DIVU in one cycle (HI <- src_a, LO <- all ones) without going busy.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   op_valid  operation offered this cycle
//   op_ready  operation can be accepted (= ~busy, from state only)
//   op        operation code (hilo_pkg OP_*)
//   src_a     rs: dividend / multiplicand / MTHI-MTLO source
//   src_b     rt: divisor / multiplier
//   cancel    flush: drops an offered op or aborts a running divide
//   busy      divide in progress
//   hi, lo    architectural HI/LO registers
module hilo_ctrl
    import hilo_pkg::*;
#(
    parameter int WIDTH = HILO_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef HILO_DIV_ZERO_FAST_EN
    localparam bit ZERO_FAST = 1'b1;
`else
    localparam bit ZERO_FAST = 1'b0;
`endif

    logic [0:0]                state_p0;
    logic                      accept;
    logic                      is_div;
    logic                      zero_fast;
    logic signed [2*WIDTH-1:0] a_ext_s;
    logic signed [2*WIDTH-1:0] b_ext_s;
    logic signed [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0]        prod_u;
    logic [WIDTH-1:0]          dvd_p0;
    logic [WIDTH-1:0]          dvs_p0;
    logic                      sgn_p0;
    logic                      div_rst;
    logic                      div_complete;
    logic [WIDTH-1:0]          div_quo;
    logic [WIDTH-1:0]          div_rem;

    assign busy     = (state_p0 == ST_DIV_RUN);
    assign op_ready = ~busy;
    assign accept   = op_valid & op_ready & ~cancel;
    assign is_div   = (op == OP_DIV) || (op == OP_DIVU);

    // Zero divisor shortcut exists only in the fast build.
    assign zero_fast = ZERO_FAST && (src_b == '0);

    // Sign/zero extension to full product width keeps the multiply exact
    // modulo 2^(2*WIDTH) for both flavours.
    assign a_ext_s = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign b_ext_s = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign prod_s  = a_ext_s * b_ext_s;
    assign prod_u  = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

    // A flush also clears the divider so the next run starts from cycle 0.
    assign div_rst = reset | cancel;

    // Stage 0: divide operand capture; the divider reads only these
    always_ff @(posedge clk) begin
        if (accept && is_div) begin
            dvd_p0 <= src_a;
            dvs_p0 <= src_b;
            sgn_p0 <= (op == OP_DIV);
        end
    end

    div #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (clk),
        .reset    (div_rst),
        .en       (busy),
        .signed_op(sgn_p0),
        .dividend (dvd_p0),
        .divisor  (dvs_p0),
        .complete (div_complete),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    // Stage 0: FSM and architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0 <= ST_IDLE;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state_p0)
                ST_IDLE: begin
                    if (accept) begin
                        case (op)
                            OP_MULT: begin
                                hi <= prod_s[2*WIDTH-1:WIDTH];
                                lo <= prod_s[WIDTH-1:0];
                            end
                            OP_MULTU: begin
                                hi <= prod_u[2*WIDTH-1:WIDTH];
                                lo <= prod_u[WIDTH-1:0];
                            end
                            OP_DIV, OP_DIVU: begin
                                if (zero_fast) begin
                                    hi <= src_a;
                                    lo <= '1;
                                end else begin
                                    state_p0 <= ST_DIV_RUN;
                                end
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                ST_DIV_RUN: begin
                    // A flush wins over a completing divide.
                    if (cancel) begin
                        state_p0 <= ST_IDLE;
                    end else if (div_complete) begin
                        lo       <= div_quo;
                        hi       <= div_rem;
                        state_p0 <= ST_IDLE;
                    end
                end
                default: state_p0 <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: directed cases with literal expectations
// followed by randomized traffic, all compared every cycle against a
// behavioural HI/LO model built from plain integer arithmetic.
module tb_hilo_ctrl;
    import hilo_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk      = 1'b0;
    logic         reset    = 1'b1;
    logic         op_valid = 1'b0;
    logic         cancel   = 1'b0;
    logic [2:0]   op       = 3'd0;
    logic [W-1:0] src_a    = '0;
    logic [W-1:0] src_b    = '0;
    logic         op_ready;
    logic         busy;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    hilo_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .cancel  (cancel),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_hi   = '0;
    logic [W-1:0] m_lo   = '0;
    logic [W-1:0] p_hi   = '0;
    logic [W-1:0] p_lo   = '0;
    bit           p_unk  = 1'b0;
    bit           unk_hi = 1'b0;
    bit           unk_lo = 1'b0;
    int           m_left = 0;   // busy cycles still to come

    always @(posedge clk or posedge reset) begin
        longint       sa, sb, q, r, pr;
        logic [63:0]  pu;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; unk_hi = 0; unk_lo = 0;
        end else if (m_left > 0) begin
            if (cancel) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    if (p_unk) begin
                        unk_hi = 1; unk_lo = 1;
                    end else begin
                        m_hi = p_hi; m_lo = p_lo; unk_hi = 0; unk_lo = 0;
                    end
                end
            end
        end else if (op_valid && !cancel) begin
            case (op)
                3'd0: begin
                    pr = longint'($signed(src_a)) * longint'($signed(src_b));
                    m_hi = pr[63:32]; m_lo = pr[31:0]; unk_hi = 0; unk_lo = 0;
                end
                3'd1: begin
                    pu = {32'b0, src_a} * {32'b0, src_b};
                    m_hi = pu[63:32]; m_lo = pu[31:0]; unk_hi = 0; unk_lo = 0;
                end
                3'd2, 3'd3: begin
                    if (op == 3'd2) begin
                        sa = longint'($signed(src_a));
                        sb = longint'($signed(src_b));
                    end else begin
                        sa = longint'({32'b0, src_a});
                        sb = longint'({32'b0, src_b});
                    end
`ifdef HILO_DIV_ZERO_FAST_EN
                    if (sb == 0) begin
                        m_hi = src_a; m_lo = '1; unk_hi = 0; unk_lo = 0;
                    end else begin
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0]; p_unk = 0;
                        m_left = LAT;
                    end
`else
                    if (sb == 0) begin
                        p_unk = 1;
                    end else begin
                        q = sa / sb; r = sa % sb;
                        p_lo = q[31:0]; p_hi = r[31:0]; p_unk = 0;
                    end
                    m_left = LAT;
`endif
                end
                3'd4: begin m_hi = src_a; unk_hi = 0; end
                3'd5: begin m_lo = src_a; unk_lo = 0; end
                default: ;
            endcase
        end
    end

    // Every-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("busy", {63'b0, busy}, {63'b0, (m_left > 0)});
        chk("op_ready", {63'b0, op_ready}, {63'b0, (m_left == 0)});
        if (!unk_hi) chk("hi", {32'b0, hi}, {32'b0, m_hi});
        if (!unk_lo) chk("lo", {32'b0, lo}, {32'b0, m_lo});
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int acc);
        @(negedge clk);
        op = o; src_a = a; src_b = b; op_valid = 1'b1;
        for (int i = 0; i < 200 && !op_ready; i++) @(negedge clk);
        chk("accept_wait", {63'b0, op_ready}, 64'd1);
        acc = cyc;
        @(negedge clk);
        op_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 200 && busy; i++) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int acc0, acc1, n;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_hi", {32'b0, hi}, 64'd0);
        chk("rst_lo", {32'b0, lo}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_ready", {63'b0, op_ready}, 64'd1);
        reset = 1'b0;

        // MULT / MULTU
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, acc0);
        chk("mult_hi", {32'b0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'b0, lo}, 64'hFFFF_FFFE);
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, acc0);
        chk("multu_hi", {32'b0, hi}, 64'd1);
        chk("multu_lo", {32'b0, lo}, 64'hFFFF_FFFE);

        // Signed divide -7/2 with exact busy length
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, acc0);
        count_busy(n);
        chk("div_busy_len", 64'(n), 64'(LAT));
        chk("div_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'b0, hi}, 64'hFFFF_FFFF);

        // Unsigned divide 100/7
        issue(OP_DIVU, 32'd100, 32'd7, acc0);
        count_busy(n);
        chk("divu_lo", {32'b0, lo}, 64'd14);
        chk("divu_hi", {32'b0, hi}, 64'd2);

        // MTHI held behind a running divide
        issue(OP_DIVU, 32'd100, 32'd7, acc0);
        issue(OP_MTHI, 32'h1234, 32'd0, acc1);
        chk("mthi_accept_cycle", 64'(acc1 - acc0), 64'(LAT + 1));
        chk("mthi_hi", {32'b0, hi}, 64'h1234);
        chk("mthi_lo", {32'b0, lo}, 64'd14);

        // Cancel in the 10th busy cycle
        issue(OP_DIVU, 32'd100, 32'd7, acc0);
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {63'b0, busy}, 64'd0);
        chk("cancel_hi", {32'b0, hi}, 64'h1234);
        chk("cancel_lo", {32'b0, lo}, 64'd14);
        issue(OP_DIVU, 32'd9, 32'd4, acc0);
        count_busy(n);
        chk("div94_lo", {32'b0, lo}, 64'd2);
        chk("div94_hi", {32'b0, hi}, 64'd1);

        // Divide by zero
        issue(OP_DIVU, 32'd5, 32'd0, acc0);
`ifdef HILO_DIV_ZERO_FAST_EN
        chk("dz_busy", {63'b0, busy}, 64'd0);
        chk("dz_hi", {32'b0, hi}, 64'd5);
        chk("dz_lo", {32'b0, lo}, 64'hFFFF_FFFF);
`else
        count_busy(n);
        chk("dz_busy_len", 64'(n), 64'(LAT));
        chk("dz_ready", {63'b0, op_ready}, 64'd1);
`endif

        // Reset in the middle of a divide
        issue(OP_DIV, 32'd1000, 32'd3, acc0);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rstmid_busy", {63'b0, busy}, 64'd0);
        chk("rstmid_hi", {32'b0, hi}, 64'd0);
        chk("rstmid_lo", {32'b0, lo}, 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            op_valid = ($urandom_range(0, 1) == 1);
            op       = 3'($urandom_range(0, 7));
            src_a    = ($urandom_range(0, 3) == 0) ? W'(-$signed(W'($urandom_range(0, 50))))
                                                   : $urandom;
            case ($urandom_range(0, 3))
                0:       src_b = '0;
                1:       src_b = W'($urandom_range(1, 9));
                2:       src_b = W'(-$signed(W'($urandom_range(1, 9))));
                default: src_b = $urandom;
            endcase
            cancel = ($urandom_range(0, 39) == 0);
        end
        @(negedge clk);
        op_valid = 1'b0;
        cancel   = 1'b0;
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("final_idle", {63'b0, busy}, 64'd0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
